// File: rtl/parking_pkg.sv
// Shared types for the parking gate beam sensor: FSM states, 2-bit sensor codes {a,b}.
// Optional debounce filter is enabled with the PARKING_GATE_DEBOUNCE_EN macro.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EN_A,
        EN_AB,
        EN_B,
        EX_B,
        EX_BA,
        EX_A,
        WAIT_CLEAR
    } gate_state_t;

    typedef logic [1:0] sensor_code_t;

    localparam sensor_code_t S_CLR = 2'b00;
    localparam sensor_code_t S_B   = 2'b01;
    localparam sensor_code_t S_A   = 2'b10;
    localparam sensor_code_t S_AB  = 2'b11;

    localparam int TIMER_W = 16;

    // Sensor pattern that keeps each state where it is; any other code is a step or a jump.
    function automatic sensor_code_t state_code(input gate_state_t st);
        sensor_code_t code;
        case (st)
            EN_A, EX_A:   code = S_A;
            EN_AB, EX_BA: code = S_AB;
            EN_B, EX_B:   code = S_B;
            default:      code = S_CLR;
        endcase
        return code;
    endfunction

    function automatic logic is_jump(input sensor_code_t from_code, input sensor_code_t to_code);
        return (from_code ^ to_code) == 2'b11;
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// Per-beam 2-flop synchroniser followed by an optional stability filter.
// With PARKING_GATE_DEBOUNCE_EN defined, a change passes after DEBOUNCE_CYCLES stable samples.
module sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

`ifdef PARKING_GATE_DEBOUNCE_EN
    logic       r_filt;
    logic [7:0] r_cnt;

    // r_cnt counts consecutive samples disagreeing with r_filt; any agreement restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= 1'b0;
            r_cnt  <= 8'd0;
        end else if (r_sync == r_filt) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_filt <= r_sync;
            r_cnt  <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_filt = r_filt;
`else
    // No filtering: the synchronised level feeds the FSM whatever DEBOUNCE_CYCLES says.
    if (DEBOUNCE_CYCLES >= 1) begin : g_pass
        assign o_filt = r_sync;
    end else begin : g_pass_any
        assign o_filt = r_sync;
    end
`endif

endmodule

// File: rtl/parking_gate_sensor.sv
// Two-beam parking gate direction decoder: emits entry/exit/error pulses from beam order.
// Debounce on the beams is compiled in with the PARKING_GATE_DEBOUNCE_EN macro.
module parking_gate_sensor
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc_car,
    output logic dec_car,
    output logic busy,
    output logic error
);

    logic         w_a_filt;
    logic         w_b_filt;
    sensor_code_t w_s;

    gate_state_t  r_state;
    gate_state_t  w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic         w_timing;
    logic         w_inc_next;
    logic         w_dec_next;
    logic         w_err_next;
    logic         r_inc;
    logic         r_dec;
    logic         r_err;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_a (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (sensor_a),
        .o_filt (w_a_filt)
    );

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_b (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (sensor_b),
        .o_filt (w_b_filt)
    );

    assign w_s      = {w_a_filt, w_b_filt};
    assign w_timing = (r_state != IDLE) && (r_state != WAIT_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_inc   <= w_inc_next;
            r_dec   <= w_dec_next;
            r_err   <= w_err_next;
            if ((w_state_next != r_state) || !w_timing) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // A one-bit change is a forward or backward step; a two-bit change is illegal.
    always_comb begin
        w_state_next = r_state;
        w_inc_next   = 1'b0;
        w_dec_next   = 1'b0;
        w_err_next   = 1'b0;
        if (r_state == WAIT_CLEAR) begin
            if (w_s == S_CLR) begin
                w_state_next = IDLE;
            end
        end else if (w_s != state_code(r_state)) begin
            if (is_jump(state_code(r_state), w_s)) begin
                w_state_next = WAIT_CLEAR;
                w_err_next   = 1'b1;
            end else begin
                case (r_state)
                    IDLE:  w_state_next = (w_s == S_A)  ? EN_A  : EX_B;
                    EN_A:  w_state_next = (w_s == S_AB) ? EN_AB : IDLE;
                    EN_AB: w_state_next = (w_s == S_B)  ? EN_B  : EN_A;
                    EN_B: begin
                        if (w_s == S_CLR) begin
                            w_state_next = IDLE;
                            w_inc_next   = 1'b1;
                        end else begin
                            w_state_next = EN_AB;
                        end
                    end
                    EX_B:  w_state_next = (w_s == S_AB) ? EX_BA : IDLE;
                    EX_BA: w_state_next = (w_s == S_A)  ? EX_A  : EX_B;
                    EX_A: begin
                        if (w_s == S_CLR) begin
                            w_state_next = IDLE;
                            w_dec_next   = 1'b1;
                        end else begin
                            w_state_next = EX_BA;
                        end
                    end
                    default: w_state_next = IDLE;
                endcase
            end
        end else if (w_timing && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
            w_state_next = WAIT_CLEAR;
            w_err_next   = 1'b1;
        end
    end

    always_comb begin
        busy    = (r_state != IDLE);
        inc_car = r_inc;
        dec_car = r_dec;
        error   = r_err;
    end

endmodule

// File: doc/parking_gate_sensor.md
PARKING_GATE_SENSOR -- requirements
Module: parking_gate_sensor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable samples required before a sensor change is accepted (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum number of cycles allowed in any non-IDLE state (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sensor_a, input, 1 bit: outer beam, 1 = blocked, asynchronous to clk.
REQ-006 SHALL have port sensor_b, input, 1 bit: inner beam, 1 = blocked, asynchronous to clk.
REQ-007 SHALL have port inc_car, output, 1 bit: one-cycle pulse on each completed entry; drives the counter's inc_car.
REQ-008 SHALL have port dec_car, output, 1 bit: one-cycle pulse on each completed exit; drives the counter's dec_car.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port error, output, 1 bit: one-cycle pulse on an illegal sequence or a timeout.

Function
REQ-011 SHALL synchronise each sensor input through a 2-flop synchroniser; the resulting pair is s = {a,b}.
REQ-012 SHALL have FSM states IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A and WAIT_CLEAR.
REQ-013 SHALL take these entry transitions on filtered s: IDLE 10->EN_A; EN_A 11->EN_AB; EN_AB 01->EN_B; EN_B 00->IDLE, with inc_car=1 on that same edge.
REQ-014 SHALL take these exit transitions on filtered s: IDLE 01->EX_B; EX_B 11->EX_BA; EX_BA 10->EX_A; EX_A 00->IDLE, with dec_car=1 on that same edge.
REQ-015 SHALL treat a backward step (e.g. EN_AB seeing 10, EN_A seeing 00) as a move to the matching earlier state, or to IDLE, with no pulse and no error (car backed out).
REQ-016 SHALL treat a two-bit jump (IDLE seeing 11; EN_A seeing 01; EN_B seeing 10; EX_B seeing 10; EX_A seeing 01) by pulsing error and entering WAIT_CLEAR.
REQ-017 SHALL hold WAIT_CLEAR until filtered s = 00, then return to IDLE with no pulse.
REQ-018 SHALL count cycles in each non-IDLE state except WAIT_CLEAR, clearing the counter on every state change; reaching TIMEOUT_CYCLES SHALL pulse error and enter WAIT_CLEAR.
REQ-019 SHALL never assert inc_car and dec_car in the same cycle; at most one of inc_car, dec_car and error SHALL be high per cycle.
REQ-020 SHALL, when filtered s is unchanged, hold the current state (except on timeout).
REQ-021 SHALL give a pulse latency of 2 synchroniser cycles + filter delay + 1 cycle from the final raw change.

Reset
REQ-022 SHALL, while reset=1, set: state=IDLE, synchronisers=0, filter=0, counters=0, inc_car=0, dec_car=0, busy=0, error=0.
REQ-023 SHALL, on reset asserted mid-sequence, discard the sequence; no pulse SHALL follow after release unless a full new sequence completes.

Configuration
REQ-024 SHALL, with PARKING_GATE_DEBOUNCE_EN defined, accept a change on each synchronised sensor only after it has been stable for DEBOUNCE_CYCLES consecutive cycles (filter delay = DEBOUNCE_CYCLES).
REQ-025 SHALL, without PARKING_GATE_DEBOUNCE_EN, feed the synchronised values directly to the FSM (filter delay = 0); DEBOUNCE_CYCLES is then unused.

Structure
REQ-026 SHALL place the FSM state enum and a 2-bit sensor-code typedef with constants S_CLR=00, S_B=01, S_A=10, S_AB=11 in shared package parking_pkg.
REQ-027 SHALL implement the per-sensor synchroniser plus debounce as sub-module sensor_filter, instantiated twice.

Verification
REQ-028 SHALL cover entry: with the macro on and DEBOUNCE=4, a,b = 00,10,11,01,00, each held 10 cycles -> exactly one inc_car pulse, 7 cycles after the final 00; no dec_car.
REQ-029 SHALL cover exit: 00,01,11,10,00 -> exactly one dec_car pulse; busy high from the first accepted 01 until the pulse.
REQ-030 SHALL cover backing out: 00,10,11,10,00 -> no inc_car, no dec_car, no error; busy=0 at the end.
REQ-031 SHALL cover an illegal jump: 00 to 11 directly -> one error pulse, state WAIT_CLEAR; after 00, IDLE with no pulse.
REQ-032 SHALL cover timeout: with TIMEOUT_CYCLES=20, hold 10 -> error pulse 20 cycles after EN_A entry; later 00 returns to IDLE.
REQ-033 SHALL cover glitches and reset: 2-cycle glitches on sensor_a with the macro on -> no state change; reset asserted in EN_AB -> all outputs 0 and no pulse after release.
